// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - program-load encoder packing symbolic myMIPS instructions into 16-bit words
//
// Purpose: accepts one symbolic instruction per in_valid/in_ready handshake, range-checks the
// fields the opcode actually uses, packs them into a 16-bit word and presents it with an
// auto-incrementing instruction-memory address on an out_valid/out_ready port.
// Optional feature macro: ENC_BRANCH_PAD_EN (append PAD_SLOTS nop words after beq/j/jal/jr).
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   addr_load, addr_in   load next write address (IDLE only, has priority over accept)
//   in_valid, in_ready   instruction handshake
//   op_sel               operation select (0 add .. 15 nop)
//   reg_d, reg_s, reg_t  register fields (legal 0..7)
//   imm, shamt, jaddr    signed immediate (-32..31), shift amount (0..7), jump target
//   out_valid, out_ready word handshake
//   out_addr, out_data   write address and encoded word
//   enc_err              1-cycle pulse when an instruction is rejected
//   word_cnt             saturating count of emitted words
module instr_encoder #(
    parameter int AW        = 8,
    parameter int PAD_SLOTS = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          addr_load,
    input  logic [AW-1:0] addr_in,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    op_sel,
    input  logic [3:0]    reg_d,
    input  logic [3:0]    reg_s,
    input  logic [3:0]    reg_t,
    input  logic [7:0]    imm,
    input  logic [3:0]    shamt,
    input  logic [11:0]   jaddr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_addr,
    output logic [15:0]   out_data,
    output logic          enc_err,
    output logic [15:0]   word_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EMIT,
        S_PAD
    } state_t;

    state_t      state;
    logic [15:0] enc_word;
    logic        illegal;
    logic        is_branch;
    logic        imm_bad;

    // imm fits in 6 signed bits only if bits 7..5 are all copies of the sign
    assign imm_bad  = (imm[7:5] != 3'b000) && (imm[7:5] != 3'b111);
    assign in_ready = !rst && (state == S_IDLE) && !addr_load;

    always_comb begin
        enc_word  = 16'h0000;
        illegal   = 1'b0;
        is_branch = 1'b0;
        case (op_sel)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4: begin
                enc_word = {4'h0, reg_s[2:0], reg_t[2:0], reg_d[2:0], op_sel[2:0]};
                illegal  = reg_s[3] | reg_t[3] | reg_d[3];
            end
            4'd5, 4'd6: begin
                enc_word = {4'h0, reg_d[2:0], reg_s[2:0], shamt[2:0], op_sel[2:0]};
                illegal  = reg_d[3] | reg_s[3] | shamt[3];
            end
            4'd7: begin
                enc_word  = {4'h0, reg_s[2:0], 6'b000000, 3'd7};
                illegal   = reg_s[3];
                is_branch = 1'b1;
            end
            4'd8: begin
                enc_word = {4'h1, reg_d[2:0], reg_s[2:0], imm[5:0]};
                illegal  = reg_d[3] | reg_s[3] | imm_bad;
            end
            4'd9: begin
                enc_word = {4'h3, reg_d[2:0], reg_s[2:0], imm[5:0]};
                illegal  = reg_d[3] | reg_s[3] | imm_bad;
            end
            4'd10: begin
                enc_word = {4'h4, reg_s[2:0], reg_d[2:0], imm[5:0]};
                illegal  = reg_s[3] | reg_d[3] | imm_bad;
            end
            4'd11: begin
                enc_word = {4'h5, reg_s[2:0], reg_t[2:0], imm[5:0]};
                illegal  = reg_s[3] | reg_t[3] | imm_bad;
            end
            4'd12: begin
                enc_word  = {4'h6, reg_s[2:0], reg_t[2:0], imm[5:0]};
                illegal   = reg_s[3] | reg_t[3] | imm_bad;
                is_branch = 1'b1;
            end
            4'd13: begin
                enc_word  = {4'h7, jaddr};
                is_branch = 1'b1;
            end
            4'd14: begin
                enc_word  = {4'h8, jaddr};
                is_branch = 1'b1;
            end
            default: enc_word = 16'h0000;
        endcase
    end

`ifdef ENC_BRANCH_PAD_EN
    logic        pad_pend;
    logic [15:0] pad_left;
`else
    logic unused_cfg;
    assign unused_cfg = is_branch ^ (PAD_SLOTS != 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= 16'h0000;
            enc_err   <= 1'b0;
            word_cnt  <= 16'h0000;
`ifdef ENC_BRANCH_PAD_EN
            pad_pend  <= 1'b0;
            pad_left  <= 16'h0000;
`endif
        end else begin
            enc_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (addr_load) begin
                        out_addr <= addr_in;
                    end else if (in_valid) begin
                        if (illegal) begin
                            enc_err <= 1'b1;
                        end else begin
                            out_data  <= enc_word;
                            out_valid <= 1'b1;
                            state     <= S_EMIT;
`ifdef ENC_BRANCH_PAD_EN
                            pad_pend  <= is_branch;
`endif
                        end
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        out_addr <= out_addr + 1'b1;
                        if (word_cnt != 16'hFFFF) word_cnt <= word_cnt + 1'b1;
`ifdef ENC_BRANCH_PAD_EN
                        if (pad_pend && (PAD_SLOTS > 0)) begin
                            // keep out_valid high; pad words follow back-to-back
                            out_data <= 16'h0000;
                            pad_left <= 16'(PAD_SLOTS);
                            state    <= S_PAD;
                        end else begin
                            out_valid <= 1'b0;
                            state     <= S_IDLE;
                        end
`else
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
`endif
                    end
                end
                S_PAD: begin
`ifdef ENC_BRANCH_PAD_EN
                    if (out_ready) begin
                        out_addr <= out_addr + 1'b1;
                        if (word_cnt != 16'hFFFF) word_cnt <= word_cnt + 1'b1;
                        if (pad_left == 16'd1) begin
                            out_valid <= 1'b0;
                            state     <= S_IDLE;
                        end else begin
                            pad_left <= pad_left - 1'b1;
                        end
                    end
`else
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder
module tb_instr_encoder;

    localparam int AW = 8;
    localparam int PS = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          addr_load;
    logic [AW-1:0] addr_in;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    op_sel, reg_d, reg_s, reg_t, shamt;
    logic [7:0]    imm;
    logic [11:0]   jaddr;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [15:0]   out_data;
    logic          enc_err;
    logic [15:0]   word_cnt;

    instr_encoder #(.AW(AW), .PAD_SLOTS(PS)) dut (
        .clk(clk), .rst(rst), .addr_load(addr_load), .addr_in(addr_in),
        .in_valid(in_valid), .in_ready(in_ready), .op_sel(op_sel),
        .reg_d(reg_d), .reg_s(reg_s), .reg_t(reg_t), .imm(imm),
        .shamt(shamt), .jaddr(jaddr), .out_valid(out_valid),
        .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
        .enc_err(enc_err), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [AW-1:0] exp_addr;
    int            exp_cnt;

    typedef struct {
        logic [3:0]  op, d, s, t;
        logic [7:0]  im;
        logic [3:0]  sh;
        logic [11:0] ja;
        bit          ok;
        logic [15:0] w;
        int          stall;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference encoder from the ISA field rules, using integer arithmetic
    function automatic int ref_word(input int op, input int d, input int s, input int t,
                                    input int im, input int sh, input int ja, output bit ok);
        bit imm_ok = (im >= -32) && (im <= 31);
        int lo = im & 63;
        ok = 1;
        case (op)
            0, 1, 2, 3, 4: begin ok = d < 8 && s < 8 && t < 8; return s*512 + t*64 + d*8 + op; end
            5, 6:  begin ok = d < 8 && s < 8 && sh < 8; return d*512 + s*64 + sh*8 + op; end
            7:     begin ok = s < 8; return s*512 + 7; end
            8:     begin ok = d < 8 && s < 8 && imm_ok; return 1*4096 + d*512 + s*64 + lo; end
            9:     begin ok = d < 8 && s < 8 && imm_ok; return 3*4096 + d*512 + s*64 + lo; end
            10:    begin ok = s < 8 && d < 8 && imm_ok; return 4*4096 + s*512 + d*64 + lo; end
            11:    begin ok = s < 8 && t < 8 && imm_ok; return 5*4096 + s*512 + t*64 + lo; end
            12:    begin ok = s < 8 && t < 8 && imm_ok; return 6*4096 + s*512 + t*64 + lo; end
            13:    return 7*4096 + ja;
            14:    return 8*4096 + ja;
            default: return 0;
        endcase
    endfunction

    function automatic int pads_for(input int op);
`ifdef ENC_BRANCH_PAD_EN
        if (op == 7 || op == 12 || op == 13 || op == 14) return PS;
`endif
        return 0 * op;
    endfunction

    task automatic bump();
        exp_addr = exp_addr + 1'b1;
        if (exp_cnt < 65535) exp_cnt++;
    endtask

    // Entered at a negedge with the DUT idle; leaves at a negedge with the DUT idle.
    task automatic run_instr(input vec_t v, input string tag);
        logic [15:0] held;
        int np;
        op_sel = v.op; reg_d = v.d; reg_s = v.s; reg_t = v.t;
        imm = v.im; shamt = v.sh; jaddr = v.ja;
        in_valid = 1'b1;
        #1 check({tag, " in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        if (!v.ok) begin
            check({tag, " enc_err"}, enc_err, 1);
            check({tag, " no_valid"}, out_valid, 0);
            check({tag, " addr_kept"}, out_addr, exp_addr);
            check({tag, " cnt_kept"}, word_cnt, exp_cnt);
            @(negedge clk);
            check({tag, " err_pulse"}, enc_err, 0);
            return;
        end
        check({tag, " valid"}, out_valid, 1);
        check({tag, " data"}, out_data, v.w);
        check({tag, " addr"}, out_addr, exp_addr);
        check({tag, " busy"}, in_ready, 0);
        held = out_data;
        for (int i = 0; i < v.stall; i++) begin
            @(negedge clk);
            check({tag, " stall_valid"}, out_valid, 1);
            check({tag, " stall_data"}, out_data, held);
        end
        out_ready = 1'b1;
        @(negedge clk);
        bump();
        np = pads_for(int'(v.op));
        for (int p = 0; p < np; p++) begin
            check({tag, " pad_valid"}, out_valid, 1);
            check({tag, " pad_data"}, out_data, 16'h0000);
            check({tag, " pad_addr"}, out_addr, exp_addr);
            check({tag, " pad_busy"}, in_ready, 0);
            @(negedge clk);
            bump();
        end
        out_ready = 1'b0;
        check({tag, " done_valid"}, out_valid, 0);
        check({tag, " next_addr"}, out_addr, exp_addr);
        check({tag, " cnt"}, word_cnt, exp_cnt);
        check({tag, " ready_again"}, in_ready, 1);
    endtask

    task automatic load_addr(input logic [AW-1:0] a);
        addr_load = 1'b1; addr_in = a;
        #1 check("load_blocks_ready", in_ready, 0);
        @(negedge clk);
        addr_load = 1'b0;
        exp_addr = a;
        #1 check("load_addr", out_addr, a);
    endtask

    initial begin
        vec_t v;
        bit   ok;
        int   w;
        vecs[0]  = '{4'd0,  4'd3, 4'd1, 4'd2, 8'h00, 4'd0, 12'h000, 1'b1, 16'h0298, 0};
        vecs[1]  = '{4'd8,  4'd2, 4'd1, 4'd0, 8'hFF, 4'd0, 12'h000, 1'b1, 16'h147F, 1};
        vecs[2]  = '{4'd5,  4'd4, 4'd5, 4'd0, 8'h00, 4'd3, 12'h000, 1'b1, 16'h095D, 5};
        vecs[3]  = '{4'd8,  4'd2, 4'd1, 4'd0, 8'd40, 4'd0, 12'h000, 1'b0, 16'h0000, 0};
        vecs[4]  = '{4'd10, 4'd9, 4'd1, 4'd0, 8'h00, 4'd0, 12'h000, 1'b0, 16'h0000, 0};
        vecs[5]  = '{4'd10, 4'd1, 4'd2, 4'd0, 8'h05, 4'd0, 12'h000, 1'b1, 16'h4445, 0};
        vecs[6]  = '{4'd11, 4'd0, 4'd2, 4'd3, 8'hE0, 4'd0, 12'h000, 1'b1, 16'h54E0, 2};
        vecs[7]  = '{4'd9,  4'd7, 4'd0, 4'd0, 8'h1F, 4'd0, 12'h000, 1'b1, 16'h3E1F, 0};
        vecs[8]  = '{4'd6,  4'd1, 4'd2, 4'd0, 8'h00, 4'd7, 12'h000, 1'b1, 16'h02BE, 0};
        vecs[9]  = '{4'd5,  4'd1, 4'd1, 4'd0, 8'h00, 4'd8, 12'h000, 1'b0, 16'h0000, 0};
        vecs[10] = '{4'd7,  4'd9, 4'd5, 4'd9, 8'h80, 4'd9, 12'h000, 1'b1, 16'h0A07, 0};
        vecs[11] = '{4'd13, 4'd15,4'd0, 4'd0, 8'h00, 4'd0, 12'hABC, 1'b1, 16'h7ABC, 1};
        vecs[12] = '{4'd15, 4'd15,4'd15,4'd15,8'h80, 4'd15,12'hFFF, 1'b1, 16'h0000, 0};
        vecs[13] = '{4'd1,  4'd0, 4'd7, 4'd7, 8'h00, 4'd0, 12'h000, 1'b1, 16'h0FC1, 0};
        vecs[14] = '{4'd12, 4'd0, 4'd1, 4'd2, 8'h04, 4'd0, 12'h000, 1'b1, 16'h6284, 0};
        vecs[15] = '{4'd2,  4'd1, 4'd1, 4'd8, 8'h00, 4'd0, 12'h000, 1'b0, 16'h0000, 0};

        rst = 1'b1; addr_load = 1'b0; addr_in = '0; in_valid = 1'b0; out_ready = 1'b0;
        op_sel = '0; reg_d = '0; reg_s = '0; reg_t = '0; imm = '0; shamt = '0; jaddr = '0;
        exp_addr = '0; exp_cnt = 0;
        @(negedge clk); @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_valid", out_valid, 0);
        check("reset_addr", out_addr, 0);
        check("reset_data", out_data, 0);
        check("reset_err", enc_err, 0);
        check("reset_cnt", word_cnt, 0);
        @(negedge clk);

        load_addr(8'h10);
        for (int i = 0; i < 16; i++) run_instr(vecs[i], $sformatf("vec%0d", i));

        // out_ready while nothing is pending must not move address or count
        out_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        out_ready = 1'b0;
        check("idle_ready_addr", out_addr, exp_addr);
        check("idle_ready_cnt", word_cnt, exp_cnt);

        // address wrap at the top of memory
        load_addr(8'hFF);
        v = '{4'd14, 4'd0, 4'd0, 4'd0, 8'h00, 4'd0, 12'h123, 1'b1, 16'h8123, 0};
        run_instr(v, "jal_wrap");
        check("wrap_addr_zero", out_addr, 0);

`ifdef ENC_BRANCH_PAD_EN
        load_addr(8'h20);
        run_instr(vecs[14], "beq_pad");
        check("beq_pad_end", out_addr, 8'h24);
`endif

        // randomized instructions against the reference encoder
        for (int n = 0; n < 150; n++) begin
            v.op = 4'($urandom_range(0, 15));
            v.d  = 4'(($urandom_range(0, 9) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7));
            v.s  = 4'(($urandom_range(0, 9) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7));
            v.t  = 4'(($urandom_range(0, 9) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7));
            v.im = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($signed(6'($urandom)));
            v.sh = 4'($urandom_range(0, 9));
            v.ja = 12'($urandom);
            v.stall = $urandom_range(0, 2);
            w = ref_word(int'(v.op), int'(v.d), int'(v.s), int'(v.t), int'($signed(v.im)),
                         int'(v.sh), int'(v.ja), ok);
            v.ok = ok;
            v.w  = 16'(w);
            run_instr(v, $sformatf("rnd%0d", n));
        end

        // reset while a word is pending
        op_sel = 4'd0; reg_d = 4'd1; reg_s = 4'd2; reg_t = 4'd3; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("pend_valid", out_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_pend_valid", out_valid, 0);
        check("rst_pend_addr", out_addr, 0);
        check("rst_pend_cnt", word_cnt, 0);
        check("rst_pend_ready", in_ready, 0);
        rst = 1'b0;
        #1 check("rst_pend_ready_after", in_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
